pktbuf_mem_ctrl: RTL

- Parametrised packet-buffer memory controller; successor to the fixed 8x72-bit, fixed-latency eSRAM wrapper.
- Slices a DWIDTH-bit word into NUM_CH lanes with configurable depth and read latency.
- Adds read-request/response handshakes, an output FIFO for response backpressure, and a power-up init sequence.
- Sits between packet-buffer write/read logic and the on-chip buffer RAM.

---
 rtl/pktbuf_pkg.sv | 33 +++
 rtl/pktbuf_lane_ram.sv | 63 ++++++
 rtl/pktbuf_mem_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pktbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pktbuf_pkg
// Brief    : Shared sizing constants, lane-count helper and word/lane types
//            for the packet-buffer memory controller.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package pktbuf_pkg;

  localparam int PKTBUF_AWIDTH       = 12;
  localparam int PKTBUF_DEPTH        = 4096;
  localparam int PKTBUF_DWIDTH       = 520;
  localparam int PKTBUF_CH_WIDTH     = 72;
  localparam int PKTBUF_RD_LAT       = 12;
  localparam int PKTBUF_OFIFO_DEPTH  = 16;
  localparam int PKTBUF_INIT_CYCLES  = 32;

  // Number of lanes needed to hold a word; the top lane may be partly padding.
  function automatic int num_ch(input int dwidth, input int ch_width);
    return (dwidth + ch_width - 1) / ch_width;
  endfunction

  typedef logic [PKTBUF_DWIDTH-1:0]   pktbuf_word_t;
  typedef logic [PKTBUF_CH_WIDTH-1:0] pktbuf_lane_t;

  // Power-up sequencing: wait out the init window, then serve traffic.
  typedef enum logic [0:0] {
    INIT_WAIT = 1'b0,
    INIT_DONE = 1'b1
  } init_state_e;

endpackage
`default_nettype wire

// File: rtl/pktbuf_lane_ram.sv
`default_nettype none
// ============================================================================
// Module   : pktbuf_lane_ram
// Brief    : One lane of the buffer RAM. Simple dual port, read-first, with a
//            read pipeline sized so data leaves RD_LAT-1 cycles after the
//            address is presented (combinational when RD_LAT is 1).
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pktbuf_lane_ram #(
  parameter int AWIDTH   = 12,
  parameter int DEPTH    = 4096,
  parameter int CH_WIDTH = 72,
  parameter int RD_LAT   = 12
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AWIDTH-1:0]   wr_addr,
  input  logic [CH_WIDTH-1:0] wr_data,
  input  logic [AWIDTH-1:0]   rd_addr,
  input  logic                rd_zero,
  input  logic                rd_fwd,
  output logic [CH_WIDTH-1:0] rd_data
);

  logic [CH_WIDTH-1:0] mem [DEPTH];
  logic [CH_WIDTH-1:0] rd_raw;

  // Array write; callers only assert wr_en for in-range addresses.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Array read sees pre-write contents; forwarding and range masking override.
  always_comb begin
    rd_raw = mem[rd_addr];
    if (rd_fwd) begin
      rd_raw = wr_data;
    end
    if (rd_zero) begin
      rd_raw = '0;
    end
  end

  if (RD_LAT == 1) begin : g_rd_comb
    assign rd_data = rd_raw;
  end else begin : g_rd_pipe
    logic [CH_WIDTH-1:0] pipe [RD_LAT-1];

    // Delay line that aligns read data with the valid pipeline in the top.
    always_ff @(posedge clk) begin
      pipe[0] <= rd_raw;
      for (int i = 1; i < RD_LAT - 1; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end

    assign rd_data = pipe[RD_LAT-2];
  end

endmodule
`default_nettype wire

// File: rtl/pktbuf_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pktbuf_mem_ctrl
// Brief    : Packet-buffer memory controller. Lane-sliced buffer RAM with a
//            credit-based read request handshake, first-word-fall-through
//            response FIFO, power-up init window and collision counter.
//            Optional macro PKTBUF_WR_FWD_EN: same-cycle same-address reads
//            return the new write data instead of the old contents.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module pktbuf_mem_ctrl
  import pktbuf_pkg::*;
#(
  parameter int AWIDTH      = PKTBUF_AWIDTH,
  parameter int DEPTH       = PKTBUF_DEPTH,
  parameter int DWIDTH      = PKTBUF_DWIDTH,
  parameter int CH_WIDTH    = PKTBUF_CH_WIDTH,
  parameter int RD_LAT      = PKTBUF_RD_LAT,
  parameter int OFIFO_DEPTH = PKTBUF_OFIFO_DEPTH,
  parameter int INIT_CYCLES = PKTBUF_INIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_ready,
  input  logic              wren,
  input  logic [AWIDTH-1:0] wraddress,
  input  logic [DWIDTH-1:0] wrdata,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [AWIDTH-1:0] rdaddress,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DWIDTH-1:0] rddata,
  output logic [31:0]       collision_cnt
);

  localparam int NUM_CH    = num_ch(DWIDTH, CH_WIDTH);
  localparam int LANE_BITS = NUM_CH * CH_WIDTH;
  localparam int FAW       = $clog2(OFIFO_DEPTH);
  localparam int CW        = $clog2(OFIFO_DEPTH + 1);
  localparam int ICW       = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;

  // ---------------------------------------------------------------- init FSM
  init_state_e    state, state_next;
  logic [ICW-1:0] init_cnt, init_cnt_next;

  // Init state and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= INIT_WAIT;
      init_cnt <= '0;
    end else begin
      state    <= state_next;
      init_cnt <= init_cnt_next;
    end
  end

  // Count out the init window, then hold ready until the next reset.
  always_comb begin
    state_next    = state;
    init_cnt_next = init_cnt;
    mem_ready     = 1'b0;
    case (state)
      INIT_WAIT: begin
        if (init_cnt == ICW'(INIT_CYCLES - 1)) begin
          state_next = INIT_DONE;
        end else begin
          init_cnt_next = init_cnt + 1'b1;
        end
      end
      INIT_DONE: mem_ready = 1'b1;
      default:   state_next = INIT_WAIT;
    endcase
  end

  // ------------------------------------------------------ request handshake
  logic          wr_in_range, rd_in_range, wr_en, rd_accept, pop, fifo_push;
  logic          collision, fwd;
  logic [CW-1:0] credits;

  assign wr_in_range  = {1'b0, wraddress} < (AWIDTH + 1)'(DEPTH);
  assign rd_in_range  = {1'b0, rdaddress} < (AWIDTH + 1)'(DEPTH);
  assign wr_en        = wren && mem_ready && wr_in_range;
  assign rd_req_ready = mem_ready && (credits < CW'(OFIFO_DEPTH));
  assign rd_accept    = rd_req_valid && rd_req_ready;
  assign pop          = rd_valid && rd_ready;
  assign collision    = wren && rd_accept && (wraddress == rdaddress);

`ifdef PKTBUF_WR_FWD_EN
  assign fwd = collision;
`else
  assign fwd = 1'b0;
`endif

  // Credits cover every read that is in flight or parked in the FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      credits <= '0;
    end else if (rd_accept && !pop) begin
      credits <= credits + 1'b1;
    end else if (!rd_accept && pop) begin
      credits <= credits - 1'b1;
    end
  end

  // Saturating count of same-cycle same-address read/write pairs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collision_cnt <= '0;
    end else if (collision && (collision_cnt != '1)) begin
      collision_cnt <= collision_cnt + 1'b1;
    end
  end

  // --------------------------------------------------------------- lane RAMs
  logic [LANE_BITS-1:0] wr_wide, rd_wide;

  assign wr_wide = LANE_BITS'(wrdata);

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    pktbuf_lane_ram #(
      .AWIDTH   (AWIDTH),
      .DEPTH    (DEPTH),
      .CH_WIDTH (CH_WIDTH),
      .RD_LAT   (RD_LAT)
    ) u_lane (
      .clk     (clk),
      .wr_en   (wr_en),
      .wr_addr (wraddress),
      .wr_data (wr_wide[k*CH_WIDTH +: CH_WIDTH]),
      .rd_addr (rdaddress),
      .rd_zero (!rd_in_range),
      .rd_fwd  (fwd),
      .rd_data (rd_wide[k*CH_WIDTH +: CH_WIDTH])
    );
  end

  if (LANE_BITS > DWIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^rd_wide[LANE_BITS-1:DWIDTH];
  end

  // ------------------------------------------------------ latency pipeline
  if (RD_LAT == 1) begin : g_vld_direct
    assign fifo_push = rd_accept;
  end else begin : g_vld_pipe
    logic [RD_LAT-2:0] vld_pipe;

    // Valid tags travel alongside the lane read pipelines.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        vld_pipe <= '0;
      end else begin
        vld_pipe[0] <= rd_accept;
        for (int i = 1; i < RD_LAT - 1; i++) begin
          vld_pipe[i] <= vld_pipe[i-1];
        end
      end
    end

    assign fifo_push = vld_pipe[RD_LAT-2];
  end

  // ------------------------------------------------------------- output FIFO
  logic [DWIDTH-1:0] fifo_mem [OFIFO_DEPTH];
  logic [FAW:0]      wr_ptr, rd_ptr;

  // FIFO storage; overflow is impossible because credits bound occupancy.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr[FAW-1:0]] <= rd_wide[DWIDTH-1:0];
    end
  end

  // FIFO pointers carry a wrap bit to tell full from empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign rd_valid = (wr_ptr != rd_ptr);
  assign rddata   = rd_valid ? fifo_mem[rd_ptr[FAW-1:0]] : '0;

endmodule
`default_nettype wire
